// File: rtl/song_sequencer.sv
// song_sequencer
//   Autoplay controller for the piano tone path. Steps through a 32-entry
//   melody ROM (Ode to Joy) and drives a one-hot note select into the tone-clock
//   mux. A non-zero switch pattern pre-empts the sequence and freezes it.
//
// Ports
//   CLK       in   system clock, all logic on the rising edge
//   RESET_N   in   synchronous active-low reset
//   play      in   1-cycle pulse: start (IDLE), pause (NOTE/GAP), resume (PAUSE)
//   stop      in   1-cycle pulse: abort to IDLE and rewind to step 0 (beats play)
//   sw[7:0]   in   manual keys, bit7 = C4 ... bit0 = C5
//   note_sel  out  one-hot tone select, same mapping as sw, 0 = silence
//   note      out  sounding note code (0 rest, 1 = C4 ... 8 = C5)
//   playing   out  high in LOAD, NOTE and GAP
//   manual    out  high while the switches override the sequence
//   step      out  current ROM index
//   done      out  1-cycle pulse when the end marker is reached
//
// Handshake: play and stop are fire-and-forget pulses with no ready/ack. Each
// is acted on in the cycle it is sampled high. play while in LOAD is ignored.
// Every output is a register and reflects the inputs sampled one edge earlier.

module song_sequencer #(
    parameter int TICK_CYC = 12_500_000,
    parameter int GAP_CYC  = 1_250_000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       play,
    input  logic       stop,
    input  logic [7:0] sw,
    output logic [7:0] note_sel,
    output logic [3:0] note,
    output logic       playing,
    output logic       manual,
    output logic [4:0] step,
    output logic       done
);

    // Cycle counter must cover the longest possible note (dur = 15 ticks).
    localparam int CNT_W = $clog2(15 * TICK_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP,
        S_PAUSE
    } state_t;

    state_t           state_q, state_d;
    state_t           paused_q, paused_d;
    logic [4:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;

    logic [7:0]       sel_q, sel_d;
    logic [3:0]       note_q, note_d;
    logic             playing_q, playing_d;
    logic             manual_q, manual_d;
    logic             done_q, done_d;

    logic [7:0]       rom_e;
    logic [CNT_W-1:0] note_len;
    logic             play_hit;

    // Melody ROM, entry = {code[3:0], dur[3:0]}; dur = 0 marks the end.
    function automatic logic [7:0] rom_entry(input logic [4:0] idx);
        logic [7:0] e;
        case (idx)
            5'd0:  e = 8'h32;
            5'd1:  e = 8'h32;
            5'd2:  e = 8'h42;
            5'd3:  e = 8'h52;
            5'd4:  e = 8'h52;
            5'd5:  e = 8'h42;
            5'd6:  e = 8'h32;
            5'd7:  e = 8'h22;
            5'd8:  e = 8'h12;
            5'd9:  e = 8'h12;
            5'd10: e = 8'h22;
            5'd11: e = 8'h32;
            5'd12: e = 8'h33;
            5'd13: e = 8'h21;
            5'd14: e = 8'h24;
            5'd15: e = 8'h32;
            5'd16: e = 8'h32;
            5'd17: e = 8'h42;
            5'd18: e = 8'h52;
            5'd19: e = 8'h52;
            5'd20: e = 8'h42;
            5'd21: e = 8'h32;
            5'd22: e = 8'h22;
            5'd23: e = 8'h12;
            5'd24: e = 8'h12;
            5'd25: e = 8'h22;
            5'd26: e = 8'h32;
            5'd27: e = 8'h23;
            5'd28: e = 8'h11;
            5'd29: e = 8'h14;
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    // Code n selects note_sel bit (8 - n); code 0 (or out of range) is silence.
    function automatic logic [7:0] code_to_sel(input logic [3:0] c);
        logic [7:0] s;
        case (c)
            4'd1:    s = 8'b1000_0000;
            4'd2:    s = 8'b0100_0000;
            4'd3:    s = 8'b0010_0000;
            4'd4:    s = 8'b0001_0000;
            4'd5:    s = 8'b0000_1000;
            4'd6:    s = 8'b0000_0100;
            4'd7:    s = 8'b0000_0010;
            4'd8:    s = 8'b0000_0001;
            default: s = 8'b0000_0000;
        endcase
        return s;
    endfunction

    // Highest set switch wins: the ascending loop lets higher bits overwrite.
    function automatic logic [3:0] sw_to_code(input logic [7:0] s);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                c = 4'(8 - i);
            end
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        paused_d  = paused_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        done_d    = 1'b0;
        rom_e     = rom_entry(step_q);
        note_len  = CNT_W'(rom_e[3:0]) * CNT_W'(TICK_CYC) - CNT_W'(GAP_CYC);
        play_hit  = play && (state_q != S_LOAD);

        if (stop) begin
            state_d = S_IDLE;
            step_d  = 5'd0;
            cnt_d   = '0;
        end else if (play_hit) begin
            // Play transitions are taken even under manual override; the
            // counter is left untouched so a pause resumes with the same count.
            case (state_q)
                S_IDLE:  state_d = S_LOAD;
                S_NOTE,
                S_GAP: begin
                    paused_d = state_q;
                    state_d  = S_PAUSE;
                end
                S_PAUSE: state_d = paused_q;
                default: state_d = state_q;
            endcase
        end else if (sw == 8'd0) begin
            // Normal progression; skipped entirely while switches are held.
            case (state_q)
                S_LOAD: begin
                    if (rom_e[3:0] == 4'd0) begin
                        state_d = S_IDLE;
                        step_d  = 5'd0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_NOTE;
                        cnt_d   = note_len;
                        code_d  = rom_e[7:4];
                    end
                end
                S_NOTE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(GAP_CYC);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_LOAD;
                        step_d  = step_q + 5'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // Outputs are computed from the next state so they are registered
        // alongside it.
        manual_d = (sw != 8'd0);
        if (manual_d) begin
            note_d = sw_to_code(sw);
        end else if (state_d == S_NOTE) begin
            note_d = code_d;
        end else begin
            note_d = 4'd0;
        end
        sel_d     = code_to_sel(note_d);
        playing_d = (state_d == S_LOAD) || (state_d == S_NOTE) || (state_d == S_GAP);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            paused_q  <= S_IDLE;
            step_q    <= 5'd0;
            cnt_q     <= '0;
            code_q    <= 4'd0;
            sel_q     <= 8'd0;
            note_q    <= 4'd0;
            playing_q <= 1'b0;
            manual_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            paused_q  <= paused_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            sel_q     <= sel_d;
            note_q    <= note_d;
            playing_q <= playing_d;
            manual_q  <= manual_d;
            done_q    <= done_d;
        end
    end

    assign note_sel = sel_q;
    assign note     = note_q;
    assign playing  = playing_q;
    assign manual   = manual_q;
    assign step     = step_q;
    assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer with TICK_CYC = 8, GAP_CYC = 2.
// Inputs change 1 ns after each rising edge; outputs are sampled at that point,
// so each sample shows the registers updated by the edge just passed.

module tb_song_sequencer;

    localparam int TICK = 8;
    localparam int GAP  = 2;

    logic       CLK     = 1'b0;
    logic       RESET_N = 1'b0;
    logic       play    = 1'b0;
    logic       stop    = 1'b0;
    logic [7:0] sw      = 8'd0;
    logic [7:0] note_sel;
    logic [3:0] note;
    logic       playing;
    logic       manual;
    logic [4:0] step;
    logic       done;

    song_sequencer #(
        .TICK_CYC(TICK),
        .GAP_CYC (GAP)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .play    (play),
        .stop    (stop),
        .sw      (sw),
        .note_sel(note_sel),
        .note    (note),
        .playing (playing),
        .manual  (manual),
        .step    (step),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       play;
        logic       stop;
        logic [7:0] sw;
        logic [7:0] exp_sel;
        logic [3:0] exp_note;
        logic       exp_manual;
        logic       exp_playing;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    int exp_code [30] = '{3,3,4,5,5,4,3,2,1,1,2,3,3,2,2, 3,3,4,5,5,4,3,2,1,1,2,3,2,1,1};
    int exp_dur  [30] = '{2,2,2,2,2,2,2,2,2,2,2,2,3,1,4, 2,2,2,2,2,2,2,2,2,2,2,2,3,1,4};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " note_sel"}, 32'(note_sel), 32'd0);
        chk({tag, " note"},     32'(note),     32'd0);
        chk({tag, " playing"},  32'(playing),  32'd0);
        chk({tag, " manual"},   32'(manual),   32'd0);
        chk({tag, " step"},     32'(step),     32'd0);
        chk({tag, " done"},     32'(done),     32'd0);
    endtask

    initial begin
        int t;
        int idx;
        int run;
        int cur;
        int done_cnt;
        int done_t;
        int n;

        //           play  stop  sw     sel    note  man   pl
        vec[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 8'h80, 8'h80, 4'd1, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 8'h01, 8'h01, 4'd8, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 8'h05, 8'h04, 4'd6, 1'b1, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 8'hFF, 8'h80, 4'd1, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 8'h3C, 8'h20, 4'd3, 1'b1, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 8'h02, 8'h02, 4'd7, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1'b0, 8'h10, 8'h10, 4'd4, 1'b1, 1'b1};  // play honoured under override
        vec[9]  = '{1'b0, 1'b0, 8'h10, 8'h10, 4'd4, 1'b1, 1'b1};  // LOAD frozen
        vec[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
        vec[11] = '{1'b1, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};  // stop beats play
        vec[12] = '{1'b1, 1'b0, 8'h40, 8'h40, 4'd2, 1'b1, 1'b1};
        vec[13] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        RESET_N = 1'b0;
        ticks(2);
        chk_all_zero("reset");
        RESET_N = 1'b1;
        tick();
        chk("post-reset playing", 32'(playing), 32'd0);

        // ---------------- table: switch decode and play/stop in IDLE ----------------
        for (int i = 0; i < NV; i++) begin
            play = vec[i].play;
            stop = vec[i].stop;
            sw   = vec[i].sw;
            tick();
            play = 1'b0;
            stop = 1'b0;
            chk($sformatf("vec%0d note_sel", i), 32'(note_sel), 32'(vec[i].exp_sel));
            chk($sformatf("vec%0d note", i),     32'(note),     32'(vec[i].exp_note));
            chk($sformatf("vec%0d manual", i),   32'(manual),   32'(vec[i].exp_manual));
            chk($sformatf("vec%0d playing", i),  32'(playing),  32'(vec[i].exp_playing));
            chk($sformatf("vec%0d step", i),     32'(step),     32'd0);
        end
        sw = 8'd0;
        tick();

        // ---------------- first entry timing ----------------
        play = 1'b1;
        tick();
        play = 1'b0;
        chk("e0 load playing", 32'(playing), 32'd1);
        chk("e0 load sel", 32'(note_sel), 32'd0);
        chk("e0 load step", 32'(step), 32'd0);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("e0 note sel c%0d", i), 32'(note_sel), 32'h20);
            chk($sformatf("e0 note code c%0d", i), 32'(note), 32'd3);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("e0 gap sel c%0d", i), 32'(note_sel), 32'd0);
            chk($sformatf("e0 gap note c%0d", i), 32'(note), 32'd0);
            chk($sformatf("e0 gap playing c%0d", i), 32'(playing), 32'd1);
        end
        tick();
        chk("e1 load step", 32'(step), 32'd1);
        chk("e1 load sel", 32'(note_sel), 32'd0);
        chk("e1 load playing", 32'(playing), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop playing", 32'(playing), 32'd0);
        chk("stop step", 32'(step), 32'd0);

        // ---------------- full song ----------------
        play = 1'b1;
        tick();
        play = 1'b0;
        t = 1; idx = 0; run = 0; cur = 0; done_cnt = 0; done_t = 0;
        while (t <= 600) begin
            if (note_sel != 8'd0) begin
                if (run == 0) cur = int'(note);
                run++;
            end else if (run > 0) begin
                if (idx < 30) begin
                    chk($sformatf("song note %0d code", idx), 32'(cur), 32'(exp_code[idx]));
                    chk($sformatf("song note %0d len", idx), 32'(run), 32'(exp_dur[idx] * TICK - GAP));
                end
                idx++;
                run = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_t = t;
                    chk("song done playing", 32'(playing), 32'd0);
                    chk("song done step", 32'(step), 32'd0);
                end
            end
            tick();
            t++;
        end
        chk("song note count", 32'(idx), 32'd30);
        chk("song done count", 32'(done_cnt), 32'd1);
        chk("song done time", 32'(done_t), 32'd544);
        chk("song end playing", 32'(playing), 32'd0);

        // ---------------- pause at remaining count 5 ----------------
        play = 1'b1;
        tick();
        play = 1'b0;
        ticks(10);
        chk("pause pre sel", 32'(note_sel), 32'h20);
        play = 1'b1;
        tick();
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("pause sel c%0d", i), 32'(note_sel), 32'd0);
            chk($sformatf("pause playing c%0d", i), 32'(playing), 32'd0);
            if (i == 19) play = 1'b1;
            tick();
            play = 1'b0;
        end
        n = 0;
        while (note_sel == 8'h20 && n < 40) begin
            n++;
            tick();
        end
        chk("pause resume len", 32'(n), 32'd5);
        chk("pause resume gap playing", 32'(playing), 32'd1);

        // ---------------- manual override mid-note ----------------
        stop = 1'b1;
        tick();
        stop = 1'b0;
        play = 1'b1;
        tick();
        play = 1'b0;
        ticks(4);
        chk("man pre sel", 32'(note_sel), 32'h20);
        sw = 8'b0000_0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("man sel c%0d", i), 32'(note_sel), 32'h04);
            chk($sformatf("man note c%0d", i), 32'(note), 32'd6);
            chk($sformatf("man flag c%0d", i), 32'(manual), 32'd1);
        end
        sw = 8'd0;
        tick();
        chk("man clear flag", 32'(manual), 32'd0);
        chk("man clear note", 32'(note), 32'd3);
        n = 0;
        while (note_sel == 8'h20 && n < 40) begin
            n++;
            tick();
        end
        chk("man resume len", 32'(n), 32'd10);

        // ---------------- play+stop together during step 12 ----------------
        stop = 1'b1;
        tick();
        stop = 1'b0;
        play = 1'b1;
        tick();
        play = 1'b0;
        ticks(204);
        chk("s12 load step", 32'(step), 32'd12);
        chk("s12 load playing", 32'(playing), 32'd1);
        ticks(3);
        chk("s12 note", 32'(note), 32'd3);
        play = 1'b1;
        stop = 1'b1;
        tick();
        play = 1'b0;
        stop = 1'b0;
        chk("s12 stop playing", 32'(playing), 32'd0);
        chk("s12 stop step", 32'(step), 32'd0);
        chk("s12 stop done", 32'(done), 32'd0);
        chk("s12 stop sel", 32'(note_sel), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("s12 no done", 32'(done_cnt), 32'd0);
        play = 1'b1;
        tick();
        play = 1'b0;
        chk("restart step", 32'(step), 32'd0);
        chk("restart playing", 32'(playing), 32'd1);
        tick();
        chk("restart sel", 32'(note_sel), 32'h20);
        chk("restart note", 32'(note), 32'd3);

        // ---------------- reset during GAP ----------------
        stop = 1'b1;
        tick();
        stop = 1'b0;
        play = 1'b1;
        tick();
        play = 1'b0;
        ticks(15);
        chk("rst pre gap sel", 32'(note_sel), 32'd0);
        chk("rst pre gap playing", 32'(playing), 32'd1);
        RESET_N = 1'b0;
        play    = 1'b1;
        tick();
        chk_all_zero("rst gap");
        RESET_N = 1'b1;
        play    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst idle playing c%0d", i), 32'(playing), 32'd0);
            chk($sformatf("rst idle sel c%0d", i), 32'(note_sel), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Autoplay controller for the piano tone path. It steps through an internal 32-entry melody ROM (Ode to Joy) and emits a one-hot note select that drives the existing tone-clock mux in place of the switches. A live switch on sw[7:0] pre-empts the sequence. The block owns play, pause and stop sequencing and the note/articulation-gap timing.

## Interface
- TICK_CYC, 12_500_000: CLK cycles per duration tick (one eighth note). Must be at least 2.
- GAP_CYC, 1_250_000: silent articulation cycles at the end of each note. Requires 1 ≤ GAP_CYC < TICK_CYC.
- CLK  input  1  system clock; all logic on its rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- play  input  1  single-cycle pulse: start from IDLE, pause from NOTE/GAP, resume from PAUSE.
- stop  input  1  single-cycle pulse: abort to IDLE and rewind to step 0.
- sw  input  8  manual keys; bit7=C4 … bit0=C5.
- note_sel  output  8  one-hot tone select, same bit mapping as sw; 0 = silence.
- note  output  4  code of the sounding note (0 = rest, 1=C4, 2=D, 3=E, 4=F, 5=G, 6=A, 7=B, 8=C5).
- playing  output  1  high in LOAD, NOTE and GAP.
- manual  output  1  high while the switches override the sequence.
- step  output  5  current ROM index.
- done  output  1  one-cycle pulse when the end marker is reached.

## Operation
- Every output is a register. Reset value of all outputs is 0; state resets to IDLE, step to 0, and both counters to 0.
- ROM entry format is {code[3:0], dur[3:0]}, with dur in ticks. An entry with dur=0 is the end marker.
- ROM contents (code:dur):
  - 0–14: 3:2 3:2 4:2 5:2 5:2 4:2 3:2 2:2 1:2 1:2 2:2 3:2 3:3 2:1 2:4
  - 15–29: 3:2 3:2 4:2 5:2 5:2 4:2 3:2 2:2 1:2 1:2 2:2 3:2 2:3 1:1 1:4
  - 30–31: 0:0
- Code→select mapping: note_sel bit (8−code) is set. Code 0 gives note_sel=0.
- States:
  - IDLE: on play → LOAD.
  - LOAD (1 cycle): read ROM[step]. If dur=0 → IDLE, done=1, step=0. Otherwise → NOTE.
  - NOTE: lasts dur·TICK_CYC − GAP_CYC cycles with note_sel driven, then → GAP.
  - GAP: lasts GAP_CYC cycles with note_sel=0 and note=0. Then step+1 and → LOAD.
  - PAUSE: counters and step hold, outputs silent. On play → the state that was paused, continuing with the remaining count.
- stop in any state → IDLE, step=0, counters cleared, no done pulse.
- stop and play in the same cycle: stop wins.
- Manual override:
  - If sw≠0, then manual=1 and note_sel = highest set sw bit only (lower bits ignored); note = its code.
  - While manual=1, sequencer counters and state are frozen. play/stop are still honoured.
  - When sw returns to 0, the sequence resumes exactly where it froze.
- Width rules:
  - Cycle counter must hold 15·TICK_CYC; size it with $clog2.
  - step is 5 bits and never wraps past 30, because the end marker rewinds it.
- RESET_N low mid-note: all state returns to reset values on that edge; the resulting silence is immediate after the edge.

## Timing
- Every input is sampled on the rising edge. Outputs reflect that sample one cycle later.
- play sampled at edge k → LOAD visible in cycle k+1. note_sel is valid from cycle k+2.
- Per-entry period is 1 + dur·TICK_CYC cycles: 1 LOAD, dur·TICK_CYC − GAP_CYC NOTE, GAP_CYC GAP.
- Whole song: 30 entries total 64 ticks, so 30 + 64·TICK_CYC cycles, then 1 LOAD for the end marker.
  - done is high in cycle k+32+64·TICK_CYC, the same cycle that playing first reads 0.
- A pause in the last GAP cycle preserves the pending step increment.
- sw change at edge k → note_sel and manual update in cycle k+1.

## Test plan
- TICK_CYC=8, GAP_CYC=2, play pulse in IDLE:
  - LOAD for 1 cycle.
  - note_sel=8'b0010_0000 and note=3 for 14 cycles.
  - 0 for 2 cycles.
  - step=1 at the next LOAD.
- Same parameters, full run → note sequence matches the ROM. done pulses exactly once, 544 cycles after play. step returns to 0 and playing=0.
- Pause in mid-NOTE at remaining count 5, hold 20 cycles, then play → the same note sounds for exactly 5 more cycles. note_sel=0 throughout PAUSE.
- During NOTE, set sw=8'b0000_0101:
  - note_sel=8'b0000_0100, note=6, manual=1; the counter is frozen.
  - Clear sw → the sequenced note resumes with its remaining count intact.
- play and stop in the same cycle during step 12 → IDLE, step=0, no done. A later play restarts at entry 0.
- RESET_N low for 1 cycle during GAP → all outputs 0 the next cycle, state IDLE. play pulses are ignored while RESET_N is low.
